// File: rtl/ring_counter_pkg.sv
// Shared constants and helpers for the ring/Johnson shift counter.
// Holds the mode and direction encodings and the home-pattern function.
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Home pattern as an integer: ring home has only bit 0 set and Johnson
    // home is all zeros. A zero-width counter has no home bit at all.
    // Callers size-cast the result to their own counter width.
    function automatic int unsigned home_val(input logic mode, input int unsigned w);
        return (mode == MODE_JOHNSON || w == 0) ? 0 : 1;
    endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality checker for the ring/Johnson counter state.
// A ring state is legal only when exactly one bit is set. A Johnson state is
// legal when at most one pair of adjacent bits differs.
module ring_state_check
    import ring_counter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] q,
    input  logic         mode_q,
    output logic         illegal
);

    logic [W-2:0] edges;

    // Each set bit marks a boundary between bit i and bit i+1.
    assign edges = q[W-2:0] ^ q[W-1:1];

    // Select the legality rule for the active mode.
    always_comb begin
        if (mode_q == MODE_JOHNSON) begin
            illegal = ($countones(edges) > 1);
        end else begin
            illegal = ($countones(q) != 1);
        end
    end

endmodule

// File: rtl/ring_counter_param.sv
// Parametrised W-bit shift counter: ring (one-hot, period W) or Johnson
// (period 2W), with enable, direction, seed load, step position and a wrap
// pulse. Optional build macro SELF_CORRECT_EN adds illegal-state detection:
// an enabled step from an illegal state snaps the counter back to home and
// pulses err instead of shifting. Without the macro err stays 0.
module ring_counter_param
    import ring_counter_pkg::*;
#(
    parameter  int W  = 4,
    localparam int PW = $clog2(2 * W)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic          en,
    input  logic          dir,
    input  logic          mode,
    input  logic [W-1:0]  seed,
    output logic [W-1:0]  q,
    output logic [PW-1:0] pos,
    output logic          tc,
    output logic          err
);

    logic [W-1:0]  cnt_q,  cnt_d;
    logic [PW-1:0] pos_q,  pos_d;
    logic          tc_q,   tc_d;
    logic          err_q,  err_d;
    logic          mode_q, mode_d;

    logic [W-1:0]  home;
    logic [W-1:0]  clr_home;
    logic [PW-1:0] pos_last;
    logic [W-1:0]  step_val;
    logic [PW-1:0] step_pos;
    logic          illegal;

    // Home for the latched mode (stepping) and for the incoming mode (clear).
    assign home     = W'(home_val(mode_q, W));
    assign clr_home = W'(home_val(mode, W));

    // Last position of the current period: W-1 for ring, 2W-1 for Johnson.
    assign pos_last = (mode_q == MODE_JOHNSON) ? PW'(2 * W - 1) : PW'(W - 1);

`ifdef SELF_CORRECT_EN
    ring_state_check #(
        .W (W)
    ) u_check (
        .q       (cnt_q),
        .mode_q  (mode_q),
        .illegal (illegal)
    );
`else
    assign illegal = 1'b0;
`endif

    // Shifted pattern and position after one step in the requested direction.
    // The bit fed back is the bit shifted out, inverted in Johnson mode.
    always_comb begin
        if (dir == DIR_DOWN) begin
            step_val = {cnt_q[0] ^ mode_q, cnt_q[W-1:1]};
            step_pos = (pos_q == '0) ? pos_last : pos_q - PW'(1);
        end else begin
            step_val = {cnt_q[W-2:0], cnt_q[W-1] ^ mode_q};
            step_pos = (pos_q == pos_last) ? '0 : pos_q + PW'(1);
        end
    end

    // Next-state selection for load and step; clear is applied in the register.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        tc_d   = 1'b0;
        err_d  = 1'b0;
        mode_d = mode_q;
        if (load) begin
            mode_d = mode;
            cnt_d  = seed;
            pos_d  = '0;
        end else if (en) begin
            if (illegal) begin
                cnt_d = home;
                pos_d = '0;
                err_d = 1'b1;
            end else begin
                cnt_d = step_val;
                pos_d = step_pos;
                tc_d  = (step_val == home);
            end
        end
    end

    // State register with synchronous clear, which outranks load and step.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (clr) begin
            mode_q <= mode;
            cnt_q  <= clr_home;
            pos_q  <= '0;
            tc_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            tc_q   <= tc_d;
            err_q  <= err_d;
        end
    end

    assign q   = cnt_q;
    assign pos = pos_q;
    assign tc  = tc_q;
    assign err = err_q;

endmodule

// File: tb/tb_ring_counter_param.sv
// Self-checking bench for ring_counter_param (W=4). A behavioural model works
// on integers (multiply/divide for shifts, modulo for position) and is checked
// against the DUT every cycle; directed sequences also pin literal values.
// Expectations follow SELF_CORRECT_EN when the bench is built with it.
module tb_ring_counter_param;

    localparam int W = 4;
    localparam int PW = $clog2(2 * W);

    logic          clk;
    logic          clr, load, en, dir, mode;
    logic [W-1:0]  seed;
    logic [W-1:0]  q;
    logic [PW-1:0] pos;
    logic          tc, err;

    int total = 0;
    int bad   = 0;

    // model state
    bit m_valid = 0;
    int m_q, m_pos, m_tc, m_err, m_mode;

    ring_counter_param #(.W(W)) dut (
        .clk  (clk),
        .clr  (clr),
        .load (load),
        .en   (en),
        .dir  (dir),
        .mode (mode),
        .seed (seed),
        .q    (q),
        .pos  (pos),
        .tc   (tc),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input int v, input int md);
        int n = 0;
        if (md == 0) begin
            for (int i = 0; i < W; i++) n += (v >> i) & 1;
            return n == 1;
        end
        for (int i = 0; i < W - 1; i++) n += (((v >> i) & 1) != ((v >> (i + 1)) & 1)) ? 1 : 0;
        return n <= 1;
    endfunction

    // Reference model: advances on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        int home, per, b;
        if (clr) begin
            m_valid = 1;
            m_mode = int'(mode);
            m_q = mode ? 0 : 1;
            m_pos = 0; m_tc = 0; m_err = 0;
        end else if (load) begin
            m_mode = int'(mode);
            m_q = int'(seed);
            m_pos = 0; m_tc = 0; m_err = 0;
        end else if (en) begin
            home = m_mode ? 0 : 1;
            per  = m_mode ? 2 * W : W;
            m_tc = 0; m_err = 0;
`ifdef SELF_CORRECT_EN
            if (!legal(m_q, m_mode)) begin
                m_q = home; m_pos = 0; m_err = 1;
            end else
`endif
            begin
                if (!dir) begin
                    b = m_q / (1 << (W - 1));
                    if (m_mode) b = 1 - b;
                    m_q = (m_q * 2) % (1 << W) + b;
                    m_pos = (m_pos + 1) % per;
                end else begin
                    b = m_q % 2;
                    if (m_mode) b = 1 - b;
                    m_q = m_q / 2 + b * (1 << (W - 1));
                    m_pos = (m_pos + per - 1) % per;
                end
                m_tc = (m_q == home) ? 1 : 0;
            end
        end else begin
            m_tc = 0; m_err = 0;
        end
    end

    // Compare process: DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cmp_q",   int'(q),   m_q);
            check("cmp_pos", int'(pos), m_pos);
            check("cmp_tc",  int'(tc),  m_tc);
            check("cmp_err", int'(err), m_err);
        end
    end

    // Apply one set of inputs for one edge; return just after the edge.
    task automatic cyc(input logic c, input logic l, input logic e, input logic d,
                       input logic m, input logic [W-1:0] s);
        clr = c; load = l; en = e; dir = d; mode = m; seed = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_q4[4]  = '{2, 4, 8, 1};
        int exp_q8[8]  = '{1, 3, 7, 15, 14, 12, 8, 0};
        clr = 0; load = 0; en = 0; dir = 0; mode = 0; seed = '0;
        #1;

        // 1. clear into ring mode
        cyc(1, 0, 0, 0, 0, 4'b0000);
        check("t1_q", int'(q), 1);
        check("t1_pos", int'(pos), 0);
        check("t1_tc", int'(tc), 0);
        check("t1_err", int'(err), 0);

        // 2. ring up, one full period
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 0, 4'b0000);
            check("t2_q", int'(q), exp_q4[i]);
            check("t2_pos", int'(pos), (i + 1) % 4);
            check("t2_tc", int'(tc), (i == 3) ? 1 : 0);
        end

        // 3. Johnson up, one full period
        cyc(1, 0, 0, 0, 1, 4'b0000);
        check("t3_home", int'(q), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0, 0, 4'b0000);
            check("t3_q", int'(q), exp_q8[i]);
            check("t3_pos", int'(pos), (i + 1) % 8);
            check("t3_tc", int'(tc), (i == 7) ? 1 : 0);
        end

        // 4. ring down wraps position, then hold
        cyc(1, 0, 0, 0, 0, 4'b0000);
        cyc(0, 0, 1, 1, 0, 4'b0000);
        check("t4_q", int'(q), 8);
        check("t4_pos", int'(pos), 3);
        check("t4_tc", int'(tc), 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 1, 0, 4'b0000);
            check("t4_hold_q", int'(q), 8);
            check("t4_hold_pos", int'(pos), 3);
        end

        // 5. priority clr > load > en, mode ignored without load
        cyc(1, 1, 0, 0, 0, 4'b0100);
        check("t5_clr_wins", int'(q), 1);
        cyc(0, 1, 1, 0, 0, 4'b0100);
        check("t5_load_q", int'(q), 4);
        check("t5_load_pos", int'(pos), 0);
        cyc(0, 0, 1, 0, 1, 4'b0000);
        check("t5_mode_ignored", int'(q), 8);
        check("t5_pos", int'(pos), 1);

        // 6. illegal seed then step
        cyc(0, 1, 0, 0, 0, 4'b0101);
        cyc(0, 0, 1, 0, 0, 4'b0000);
`ifdef SELF_CORRECT_EN
        check("t6_q", int'(q), 1);
        check("t6_err", int'(err), 1);
        check("t6_pos", int'(pos), 0);
        cyc(0, 0, 0, 0, 0, 4'b0000);
        check("t6_err_drop", int'(err), 0);
`else
        check("t6_q", int'(q), 10);
        check("t6_err", int'(err), 0);
        check("t6_pos", int'(pos), 1);
`endif
        check("t6_tc", int'(tc), 0);

        // randomized phase
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            cyc(r < 4, (r >= 4 && r < 12), $urandom_range(0, 99) < 70,
                1'($urandom), 1'($urandom), 4'($urandom));
        end
        cyc(0, 0, 0, 0, 0, 4'b0000);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
